btb_table: RTL and testbench

Direct-mapped branch target buffer for the branch-prediction CPU: the stage directly upstream of the BHT. Each cycle it looks up the IF-stage PC and produces `BTBhit` and a predicted target for NPC selection and for the BHT's hit/gating logic. It is trained from the EX stage once a branch resolves. It also keeps resolved-branch and mispredict counters for the experiment report.

---
 rtl/btb_table.sv | 129 ++++++++++++
 tb/tb_btb_table.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/btb_table.sv
// btb_table: direct-mapped branch target buffer.
// Combinational lookup of the fetch PC, trained from the execute stage once a
// conditional branch resolves. Also keeps saturating counters of resolved
// branches and mispredicted branches for the experiment report.
module btb_table #(
  parameter int INDEX_W          = 6,
  parameter bit INVALIDATE_ON_NT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  // fetch-side lookup
  input  logic [31:0] PCF,
  output logic        BTBhit,
  output logic [31:0] BTBTarget,
  // execute-side training
  input  logic [31:0] EXpc,
  input  logic [31:0] BrNPC,
  input  logic        BranchE,
  input  logic [2:0]  BranchTypeE,
  input  logic        StallE,
  input  logic [1:0]  PredictMiss,
  // statistics
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam int TAG_W = 32 - INDEX_W - 2;

  // Address split: word-aligned PCs, so the two low bits never matter.
  logic [INDEX_W-1:0] look_idx;
  logic [TAG_W-1:0]   look_tag;
  logic [INDEX_W-1:0] train_idx;
  logic [TAG_W-1:0]   train_tag;

  assign look_idx  = PCF[INDEX_W+1:2];
  assign look_tag  = PCF[31:INDEX_W+2];
  assign train_idx = EXpc[INDEX_W+1:2];
  assign train_tag = EXpc[31:INDEX_W+2];

  // Byte-offset bits are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], EXpc[1:0]};

  // Valid bits live in flops so reset can clear the whole table at once;
  // tag and target carry no reset since an invalid entry hides them.
  logic [DEPTH-1:0] valid_vec;
  logic [TAG_W-1:0] tag_mem    [DEPTH];
  logic [31:0]      target_mem [DEPTH];

  // Training qualification. Reset and a held EX stage both suppress it, and
  // only conditional branches (nonzero type) train or count.
  logic train_event;
  logic train_write;
  logic train_tag_match;
  logic train_clear;

  assign train_event     = !rst && !StallE && (BranchTypeE != 3'b000);
  assign train_write     = train_event && BranchE;
  assign train_tag_match = valid_vec[train_idx] && (tag_mem[train_idx] == train_tag);
  assign train_clear     = INVALIDATE_ON_NT && train_event && !BranchE && train_tag_match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic sel;
      logic valid_reg;

      assign sel = (train_idx == INDEX_W'(gi));

      // Per-entry valid bit: set on a taken write, cleared on a matching
      // not-taken resolve when invalidation is enabled.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
        end else if (sel && train_write) begin
          valid_reg <= 1'b1;
        end else if (sel && train_clear) begin
          valid_reg <= 1'b0;
        end
      end

      assign valid_vec[gi] = valid_reg;
    end
  endgenerate

  // Tag/target storage: a taken branch always replaces whatever occupies its
  // index (direct-mapped conflict replacement).
  always_ff @(posedge clk) begin
    if (train_write) begin
      tag_mem[train_idx]    <= train_tag;
      target_mem[train_idx] <= BrNPC;
    end
  end

  // Combinational lookup: reads the pre-edge contents, so a lookup in the
  // same cycle as a write to that index sees the old entry (no bypass).
  logic entry_hit;

  always_comb begin
    entry_hit = valid_vec[look_idx] && (tag_mem[look_idx] == look_tag);
    BTBhit    = !rst && entry_hit;
    BTBTarget = 32'h0;
    if (BTBhit) begin
      BTBTarget = target_mem[look_idx];
    end
  end

  // Statistics counters: saturate at all-ones instead of wrapping.
  logic [31:0] branch_count_reg;
  logic [31:0] miss_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_reg <= 32'h0;
      miss_count_reg   <= 32'h0;
    end else if (train_event) begin
      if (branch_count_reg != 32'hFFFF_FFFF) begin
        branch_count_reg <= branch_count_reg + 32'd1;
      end
      if ((PredictMiss != 2'b00) && (miss_count_reg != 32'hFFFF_FFFF)) begin
        miss_count_reg <= miss_count_reg + 32'd1;
      end
    end
  end

  assign BranchCount = branch_count_reg;
  assign MissCount   = miss_count_reg;

endmodule

// File: tb/tb_btb_table.sv
// tb_btb_table: directed scoreboard bench for btb_table.
// Two instances share all inputs: dut0 keeps entries on not-taken resolves,
// dut1 invalidates them. The stimulus process pushes the hand-computed
// expected lookup/counter values for each checked cycle into a queue; a
// monitor on the falling edge pops and compares against both instances.
module tb_btb_table;

  typedef struct {
    string       name;
    logic        h0;
    logic [31:0] t0;
    logic        h1;
    logic [31:0] t1;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic [31:0] EXpc;
  logic [31:0] BrNPC;
  logic        BranchE;
  logic [2:0]  BranchTypeE;
  logic        StallE;
  logic [1:0]  PredictMiss;

  logic        hit0, hit1;
  logic [31:0] tgt0, tgt1;
  logic [31:0] bc0, bc1, mc0, mc1;

  exp_t sb[$];
  logic strobe;
  int   passed;
  int   total;

  btb_table #(.INDEX_W(6), .INVALIDATE_ON_NT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .PCF(PCF), .BTBhit(hit0), .BTBTarget(tgt0),
    .EXpc(EXpc), .BrNPC(BrNPC), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
    .StallE(StallE), .PredictMiss(PredictMiss),
    .BranchCount(bc0), .MissCount(mc0)
  );

  btb_table #(.INDEX_W(6), .INVALIDATE_ON_NT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .PCF(PCF), .BTBhit(hit1), .BTBTarget(tgt1),
    .EXpc(EXpc), .BrNPC(BrNPC), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
    .StallE(StallE), .PredictMiss(PredictMiss),
    .BranchCount(bc1), .MissCount(mc1)
  );

  // Clock starts high so the first falling edge precedes the first rising edge.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      $display("FAIL %s.%s actual=%h required=%h", nm, field, act, req);
    end else begin
      passed++;
    end
  endtask

  // Monitor: each strobed cycle is one presented response.
  always @(negedge clk) begin
    if (strobe) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL scoreboard underflow at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        cmp(e.name, "hit0", {31'h0, hit0}, {31'h0, e.h0});
        cmp(e.name, "tgt0", tgt0, e.t0);
        cmp(e.name, "hit1", {31'h0, hit1}, {31'h0, e.h1});
        cmp(e.name, "tgt1", tgt1, e.t1);
        cmp(e.name, "bc0", bc0, e.bc);
        cmp(e.name, "mc0", mc0, e.mc);
        cmp(e.name, "bc1", bc1, e.bc);
        cmp(e.name, "mc1", mc1, e.mc);
        $display("check %-10s PCF=%h hit=%b/%b tgt=%h/%h bc=%0d mc=%0d",
                 e.name, PCF, hit0, hit1, tgt0, tgt1, bc0, mc0);
      end
    end
  end

  // One cycle: drive inputs, optionally queue the expected response, then
  // advance to just after the next rising edge.
  task automatic cyc(input string nm, input logic r, input logic [31:0] pcf,
                     input logic [31:0] ex, input logic [31:0] npc,
                     input logic br, input logic [2:0] bt, input logic st,
                     input logic [1:0] pm, input logic chk,
                     input logic h0, input logic [31:0] t0,
                     input logic h1, input logic [31:0] t1,
                     input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    rst = r; PCF = pcf; EXpc = ex; BrNPC = npc;
    BranchE = br; BranchTypeE = bt; StallE = st; PredictMiss = pm;
    if (chk) begin
      e.name = nm; e.h0 = h0; e.t0 = t0; e.h1 = h1; e.t1 = t1; e.bc = bc; e.mc = mc;
      sb.push_back(e);
    end
    strobe = chk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    strobe = 1'b0;
    //   name         rst PCF         EXpc        BrNPC       BE  type  St pm    chk h0 t0          h1 t1          bc  mc
    // Reset with a taken branch present: must not train or count.
    cyc("rst0",       1, 32'h40,      32'h40,     32'h999,    1, 3'd1, 0, 2'd2, 0,  0, 32'h0,      0, 32'h0,      0,  0);
    cyc("rst1",       1, 32'h40,      32'h40,     32'h999,    1, 3'd1, 0, 2'd2, 1,  0, 32'h0,      0, 32'h0,      0,  0);
    // Unconditional / non-branch taken: no write, no count.
    cyc("nonbr",      0, 32'h40,      32'h40,     32'h300,    1, 3'd0, 0, 2'd1, 1,  0, 32'h0,      0, 32'h0,      0,  0);
    // Taken train of 0x40; same-cycle lookup still misses.
    cyc("train40",    0, 32'h40,      32'h40,     32'h100,    1, 3'd1, 0, 2'd0, 1,  0, 32'h0,      0, 32'h0,      0,  0);
    cyc("hit40",      0, 32'h40,      32'h0,      32'h0,      0, 3'd0, 0, 2'd0, 1,  1, 32'h100,    1, 32'h100,    1,  0);
    // Alias 0x140 onto the same index.
    cyc("train140",   0, 32'h140,     32'h140,    32'h200,    1, 3'd1, 0, 2'd0, 1,  0, 32'h0,      0, 32'h0,      1,  0);
    cyc("alias40",    0, 32'h40,      32'h0,      32'h0,      0, 3'd0, 0, 2'd0, 1,  0, 32'h0,      0, 32'h0,      2,  0);
    cyc("alias140",   0, 32'h140,     32'h0,      32'h0,      0, 3'd0, 0, 2'd0, 1,  1, 32'h200,    1, 32'h200,    2,  0);
    cyc("retrain40",  0, 32'h80,      32'h40,     32'h100,    1, 3'd1, 0, 2'd0, 1,  0, 32'h0,      0, 32'h0,      2,  0);
    // Not-taken resolve on a hitting entry, with a mispredict.
    cyc("nt40",       0, 32'h40,      32'h40,     32'h0,      0, 3'd2, 0, 2'd1, 1,  1, 32'h100,    1, 32'h100,    3,  0);
    cyc("after_nt",   0, 32'h40,      32'h0,      32'h0,      0, 3'd0, 0, 2'd0, 1,  1, 32'h100,    0, 32'h0,      4,  1);
    // Not-taken with a tag mismatch leaves the entry alone.
    cyc("nt140",      0, 32'h40,      32'h140,    32'h0,      0, 3'd2, 0, 2'd0, 1,  1, 32'h100,    0, 32'h0,      4,  1);
    cyc("after_nt2",  0, 32'h40,      32'h0,      32'h0,      0, 3'd0, 0, 2'd0, 1,  1, 32'h100,    0, 32'h0,      5,  1);
    // Stall three cycles, then release: one event, counted once.
    cyc("stall1",     0, 32'h80,      32'h80,     32'h444,    1, 3'd1, 1, 2'd2, 1,  0, 32'h0,      0, 32'h0,      5,  1);
    cyc("stall2",     0, 32'h80,      32'h80,     32'h444,    1, 3'd1, 1, 2'd2, 1,  0, 32'h0,      0, 32'h0,      5,  1);
    cyc("stall3",     0, 32'h80,      32'h80,     32'h444,    1, 3'd1, 1, 2'd2, 1,  0, 32'h0,      0, 32'h0,      5,  1);
    cyc("rdw80",      0, 32'h80,      32'h80,     32'h444,    1, 3'd1, 0, 2'd2, 1,  0, 32'h0,      0, 32'h0,      5,  1);
    cyc("hit80",      0, 32'h80,      32'h0,      32'h0,      0, 3'd0, 0, 2'd0, 1,  1, 32'h444,    1, 32'h444,    6,  2);
    // Mid-run reset: outputs gated at once, pending train dropped.
    cyc("midrst",     1, 32'h80,      32'hC0,     32'h555,    1, 3'd1, 0, 2'd3, 1,  0, 32'h0,      0, 32'h0,      6,  2);
    cyc("postrstC0",  0, 32'hC0,      32'h0,      32'h0,      0, 3'd0, 0, 2'd0, 1,  0, 32'h0,      0, 32'h0,      0,  0);
    cyc("postrst80",  0, 32'h80,      32'h0,      32'h0,      0, 3'd0, 0, 2'd0, 1,  0, 32'h0,      0, 32'h0,      0,  0);
    // Low PC bits ignored; full tag compared.
    cyc("train1243",  0, 32'h0,       32'h1243,   32'hABC,    1, 3'd4, 0, 2'd0, 1,  0, 32'h0,      0, 32'h0,      0,  0);
    cyc("hit1240",    0, 32'h1240,    32'h0,      32'h0,      0, 3'd0, 0, 2'd0, 1,  1, 32'hABC,    1, 32'hABC,    1,  0);
    cyc("tagmiss",    0, 32'h80001240,32'h0,      32'h0,      0, 3'd0, 0, 2'd0, 1,  0, 32'h0,      0, 32'h0,      1,  0);
    cyc("idle",       0, 32'h0,       32'h0,      32'h0,      0, 3'd0, 0, 2'd0, 0,  0, 32'h0,      0, 32'h0,      0,  0);
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
